// File: rtl/uart_prog_pkg.sv
// Shared definitions for the program download framing on the UART link.
// The receive side uses the same header and terminator bytes.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR55,
    GAP,
    HDRAA,
    DATA,
    TRM7F,
    TRMFF,
    FIN
  } prog_tx_state_e;

  // Handshake phase of a single byte handed to the uart transmitter.
  typedef enum logic [1:0] {
    SND_WR,
    SND_LAT,
    SND_WAIT
  } prog_snd_e;

  localparam logic [7:0] PROG_HDR0 = 8'h55;
  localparam logic [7:0] PROG_HDR1 = 8'hAA;
  localparam logic [7:0] PROG_TRM0 = 8'h7F;
  localparam logic [7:0] PROG_TRM1 = 8'hFF;

  function automatic logic [7:0] prog_frame_byte(input prog_tx_state_e s);
    logic [7:0] b;
    b = PROG_HDR0;
    case (s)
      HDRAA:   b = PROG_HDR1;
      TRM7F:   b = PROG_TRM0;
      TRMFF:   b = PROG_TRM1;
      default: b = PROG_HDR0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_prog_sender.sv
// Frames an upstream byte stream as 0x55, idle gap, 0xAA, payload, 0x7F, 0xFF
// and feeds it to an external uart transmitter through its byte interface.
module uart_prog_sender
  import uart_prog_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 27_000_000,
  parameter int unsigned GAP_CYCLES = CLOCK_HZ / 1000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [7:0]           tx_data,
  output logic                 wr,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic                 seq_err
);

  prog_tx_state_e       state_q, state_d;
  prog_snd_e            snd_q, snd_d;
  logic [19:0]          gap_q, gap_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 last_seen_q, last_seen_d;
  logic                 prev7f_q, prev7f_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic                 seq_err_q, seq_err_d;
  logic [7:0]           tx_data_q;
  logic [7:0]           tx_byte;

  always_comb begin
    state_d     = state_q;
    snd_d       = snd_q;
    gap_d       = gap_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_seen_d = last_seen_q;
    prev7f_d    = prev7f_q;
    byte_cnt_d  = byte_cnt_q;
    seq_err_d   = seq_err_q;
    wr          = 1'b0;
    tx_byte     = tx_data_q;
    in_ready    = (state_q == DATA) && !hold_full_q && !last_seen_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = HDR55;
          snd_d       = SND_WR;
          byte_cnt_d  = '0;
          seq_err_d   = 1'b0;
          hold_full_d = 1'b0;
          last_seen_d = 1'b0;
          prev7f_d    = 1'b0;
        end
      end
      HDR55, HDRAA, TRM7F, TRMFF: begin
        case (snd_q)
          SND_WR: begin
            if (tx_ready) begin
              wr      = 1'b1;
              tx_byte = prog_frame_byte(state_q);
              snd_d   = SND_LAT;
            end
          end
          SND_LAT: snd_d = SND_WAIT;
          default: begin
            if (tx_ready) begin
              snd_d = SND_WR;
              case (state_q)
                HDR55: begin
                  state_d = GAP;
                  gap_d   = '0;
                end
                HDRAA:   state_d = DATA;
                TRM7F:   state_d = TRMFF;
                default: state_d = FIN;
              endcase
            end
          end
        endcase
      end
      GAP: begin
        if (gap_q == 20'(GAP_CYCLES - 1)) state_d = HDRAA;
        else                               gap_d   = gap_q + 20'd1;
      end
      DATA: begin
        // Accept only fires with the hold empty and a send needs it full,
        // so the two updates below never touch the hold in the same clock.
        if (in_ready && in_valid) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
          last_seen_d = in_last;
        end
        case (snd_q)
          SND_WR: begin
            if (hold_full_q && tx_ready) begin
              wr          = 1'b1;
              tx_byte     = hold_q;
              hold_full_d = 1'b0;
              snd_d       = SND_LAT;
              prev7f_d    = (hold_q == PROG_TRM0);
              if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
              if (prev7f_q && hold_q == PROG_TRM1) seq_err_d = 1'b1;
            end
          end
          SND_LAT: snd_d = SND_WAIT;
          default: begin
            if (tx_ready) begin
              snd_d = SND_WR;
              if (last_seen_q && !hold_full_q) state_d = TRM7F;
            end
          end
        endcase
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snd_q       <= SND_WR;
      gap_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_seen_q <= 1'b0;
      prev7f_q    <= 1'b0;
      byte_cnt_q  <= '0;
      seq_err_q   <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      snd_q       <= snd_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_seen_q <= last_seen_d;
      prev7f_q    <= prev7f_d;
      byte_cnt_q  <= byte_cnt_d;
      seq_err_q   <= seq_err_d;
      tx_data_q   <= tx_byte;
    end
  end

  assign tx_data  = tx_byte;
  assign busy     = (state_q != IDLE) && (state_q != FIN);
  assign done     = (state_q == FIN);
  assign byte_cnt = byte_cnt_q;
  assign seq_err  = seq_err_q;

endmodule
